// File: rtl/trivium_pkg.sv
// Shared constants and state encoding for the Trivium keystream consumer.
package trivium_pkg;

    localparam int TRIVIUM_STATE_BITS = 288;
    localparam int TRIVIUM_WARMUP     = 4 * TRIVIUM_STATE_BITS;

    typedef enum logic {
        WARMUP = 1'b0,
        FILL   = 1'b1
    } deser_state_e;

endpackage

// File: rtl/trivium_ks_deser.sv
// Drives the Trivium core enable, discards the warm-up bits and packs the
// following keystream bits MSB-first into DATA_W-bit words.
module trivium_ks_deser
    import trivium_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int WARMUP_CYCLES = TRIVIUM_WARMUP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ks_bit,
    input  logic              i_consume,
    output logic              o_ks_enable,
    output logic [DATA_W-1:0] o_ks_word,
    output logic              o_ks_full,
    output logic              o_warm_done
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_MAX  = WARM_W'(WARMUP_CYCLES);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    deser_state_e      r_state;
    logic [WARM_W-1:0] r_warm_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_ks_word;
    logic              r_ks_full;
    logic              r_warm_done;
    logic              w_step;

    // A full word freezes the core, so no keystream bit is dropped or reused.
    assign w_step      = (r_state == WARMUP) || !r_ks_full;
    assign o_ks_enable = w_step && !rst;
    assign o_ks_word   = r_ks_word;
    assign o_ks_full   = r_ks_full;
    assign o_warm_done = r_warm_done;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value of the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WARMUP;
            r_warm_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_ks_word   <= '0;
            r_ks_full   <= 1'b0;
            r_warm_done <= 1'b0;
        end else begin
            // Consume only happens while full, i.e. never on a stepping edge.
            if (i_consume) begin
                r_ks_full <= 1'b0;
            end
            if (w_step) begin
                case (r_state)
                    WARMUP: begin
                        if (r_warm_cnt != WARM_MAX) begin
                            r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                        end
                        if (r_warm_cnt == WARM_LAST) begin
                            r_warm_done <= 1'b1;
                            r_state     <= FILL;
                        end
                    end
                    FILL: begin
                        r_ks_word <= {r_ks_word[DATA_W-2:0], i_ks_bit};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_ks_full <= 1'b1;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                    default: r_state <= WARMUP;
                endcase
            end
        end
    end

endmodule

// File: rtl/trivium_stream_xor.sv
// XORs input words with packed Trivium keystream words over valid/ready;
// the same block encrypts and decrypts.
module trivium_stream_xor
    import trivium_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int WARMUP_CYCLES = TRIVIUM_WARMUP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ks_bit,
    output logic              ks_enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              warm_done
);

    logic [DATA_W-1:0] w_ks_word;
    logic              w_ks_full;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    trivium_ks_deser #(
        .DATA_W        (DATA_W),
        .WARMUP_CYCLES (WARMUP_CYCLES)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .i_ks_bit    (ks_bit),
        .i_consume   (w_in_fire),
        .o_ks_enable (ks_enable),
        .o_ks_word   (w_ks_word),
        .o_ks_full   (w_ks_full),
        .o_warm_done (warm_done)
    );

    // Accept only when a word is ready and the output slot frees this cycle.
    assign in_ready   = w_ks_full && (!r_out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ w_ks_word;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Self-checking bench: directed vectors, backpressure, mid-fill reset,
// randomized scoreboard and an encrypt/decrypt loopback on a Trivium model.
module tb_trivium_stream_xor;
    import trivium_pkg::*;

    localparam int DATA_W = 8;
    localparam int WARM   = TRIVIUM_WARMUP;
    localparam int SRC_N  = WARM + DATA_W * 64;
    localparam int TRI_N  = WARM + DATA_W * 72;
    localparam int N_RAND = 40;
    localparam int N_LB   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Main DUT with an array-backed keystream source.
    logic              rst = 1'b1;
    logic              ks_bit, ks_enable, in_valid, in_ready;
    logic              out_valid, out_ready, warm_done;
    logic [DATA_W-1:0] in_data, out_data;
    logic              src [SRC_N];
    int                src_step = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) src_step <= 0;
        else if (ks_enable) src_step <= src_step + 1;
    end
    assign ks_bit = (src_step < SRC_N) ? src[src_step] : 1'b0;

    trivium_stream_xor #(.DATA_W(DATA_W), .WARMUP_CYCLES(WARM)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ks_bit    (ks_bit),
        .ks_enable (ks_enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .warm_done (warm_done)
    );

    // Loopback pair, each fed by its own copy of the same Trivium keystream.
    logic              lb_rst = 1'b1;
    logic              tri_bits [TRI_N];
    int                enc_step = 0;
    int                dec_step = 0;
    logic              enc_ks_bit, enc_ks_enable, enc_in_valid, enc_in_ready;
    logic              enc_out_valid, enc_out_ready, enc_warm_done;
    logic [DATA_W-1:0] enc_in_data, enc_out_data;
    logic              dec_ks_bit, dec_ks_enable, dec_in_ready;
    logic              dec_out_valid, dec_out_ready, dec_warm_done;
    logic [DATA_W-1:0] dec_out_data;

    always @(posedge clk or posedge lb_rst) begin
        if (lb_rst) begin
            enc_step <= 0;
            dec_step <= 0;
        end else begin
            if (enc_ks_enable) enc_step <= enc_step + 1;
            if (dec_ks_enable) dec_step <= dec_step + 1;
        end
    end
    assign enc_ks_bit    = (enc_step < TRI_N) ? tri_bits[enc_step] : 1'b0;
    assign dec_ks_bit    = (dec_step < TRI_N) ? tri_bits[dec_step] : 1'b0;
    assign enc_out_ready = dec_in_ready;
    assign dec_out_ready = 1'b1;

    trivium_stream_xor #(.DATA_W(DATA_W), .WARMUP_CYCLES(WARM)) u_enc (
        .clk       (clk),
        .rst       (lb_rst),
        .ks_bit    (enc_ks_bit),
        .ks_enable (enc_ks_enable),
        .in_valid  (enc_in_valid),
        .in_ready  (enc_in_ready),
        .in_data   (enc_in_data),
        .out_valid (enc_out_valid),
        .out_ready (enc_out_ready),
        .out_data  (enc_out_data),
        .warm_done (enc_warm_done)
    );

    trivium_stream_xor #(.DATA_W(DATA_W), .WARMUP_CYCLES(WARM)) u_dec (
        .clk       (clk),
        .rst       (lb_rst),
        .ks_bit    (dec_ks_bit),
        .ks_enable (dec_ks_enable),
        .in_valid  (enc_out_valid),
        .in_ready  (dec_in_ready),
        .in_data   (enc_out_data),
        .out_valid (dec_out_valid),
        .out_ready (dec_out_ready),
        .out_data  (dec_out_data),
        .warm_done (dec_warm_done)
    );

    typedef struct {
        logic [DATA_W-1:0] ks;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dout;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    // Keystream word n is the n-th group of DATA_W bits after warm-up, first bit in the MSB.
    function automatic logic [DATA_W-1:0] src_word(input int n);
        logic [DATA_W-1:0] w;
        for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = src[WARM + DATA_W*n + b];
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] tri_word(input int n);
        logic [DATA_W-1:0] w;
        for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = tri_bits[WARM + DATA_W*n + b];
        return w;
    endfunction

    task automatic put_word(input int n, input logic [DATA_W-1:0] w);
        for (int b = 0; b < DATA_W; b++) src[WARM + DATA_W*n + b] = w[DATA_W-1-b];
    endtask

    // Bit-level Trivium: core output z for every step from key/IV load onward.
    task automatic gen_trivium(input logic [79:0] key, input logic [79:0] iv);
        logic s [1:288];
        logic t1, t2, t3;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            s[1 + i]  = key[i];
            s[94 + i] = iv[i];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        for (int k = 0; k < TRI_N; k++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            tri_bits[k] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int j = 93; j >= 2; j--) s[j] = s[j-1];
            s[1] = t3;
            for (int j = 177; j >= 95; j--) s[j] = s[j-1];
            s[94] = t1;
            for (int j = 288; j >= 179; j--) s[j] = s[j-1];
            s[178] = t2;
        end
    endtask

    task automatic wait_warm(output int edges, output logic saw_ready);
        edges     = 0;
        saw_ready = 1'b0;
        while (!warm_done && edges < WARM + 100) begin
            @(negedge clk);
            edges++;
            if (in_ready) saw_ready = 1'b1;
        end
    endtask

    task automatic wait_full(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int                edges, cyc, n_in, n_out, pt, ecnt, dcnt;
        logic              saw;
        logic [DATA_W-1:0] q [$];

        vecs[0] = '{ks: 8'h00, din: 8'h3C, dout: 8'h3C};
        vecs[1] = '{ks: 8'hA5, din: 8'hFF, dout: 8'h5A};
        vecs[2] = '{ks: 8'hFF, din: 8'h0F, dout: 8'hF0};
        vecs[3] = '{ks: 8'h81, din: 8'h81, dout: 8'h00};

        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        enc_in_valid = 1'b0;
        enc_in_data  = '0;

        for (int i = 0; i < WARM; i++) src[i] = 1'b1;
        for (int i = 0; i < 4; i++) put_word(i, vecs[i].ks);
        put_word(4, 8'h3C);
        put_word(5, 8'hC3);
        for (int i = 6; i < 64; i++) put_word(i, 8'($urandom));
        gen_trivium(80'h0123_4567_89AB_CDEF_1357, 80'hFEDC_BA98_7654_3210_2468);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ks_enable", ks_enable, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_warm_done", warm_done, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1 check("ks_enable_after_rst", ks_enable, 1);

        // Warm-up with input pending: must not be accepted.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        wait_warm(edges, saw);
        check("warmup_edges", edges, WARM);
        check("no_accept_in_warmup", saw, 0);
        check("no_out_in_warmup", out_valid, 0);
        in_valid = 1'b0;

        // Directed words: fill time, idle keystream while full, 1-cycle latency.
        for (int i = 0; i < 4; i++) begin
            wait_full(cyc);
            check($sformatf("fill_cycles[%0d]", i), cyc, DATA_W);
            repeat (2) @(negedge clk);
            check($sformatf("ks_idle_full[%0d]", i), ks_enable, 0);
            check($sformatf("ready_full[%0d]", i), in_ready, 1);
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec_valid[%0d]", i), out_valid, 1);
            check($sformatf("vec_data[%0d]", i), out_data, vecs[i].dout);
            check($sformatf("vec_ready_drop[%0d]", i), in_ready, 0);
        end

        // Backpressure: held output plus a full next word stalls everything.
        wait_full(cyc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        @(negedge clk);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_data", out_data, 8'h2D);
        in_data = 8'h22;
        repeat (DATA_W) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp_ready[%0d]", i), in_ready, 0);
            check($sformatf("bp_ks_en[%0d]", i), ks_enable, 0);
            check($sformatf("bp_hold[%0d]", i), out_data, 8'h2D);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        @(negedge clk);
        check("bp_both_fire_valid", out_valid, 1);
        check("bp_both_fire_data", out_data, 8'hE1);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset three bits into the next word while an output is held.
        repeat (3) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_ks_enable", ks_enable, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_warm_done", warm_done, 0);
        check("midrst_out_data", out_data, 0);
        #1 rst = 1'b0;
        #1 check("midrst_ks_enable_release", ks_enable, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        wait_warm(edges, saw);
        check("rewarm_edges", edges, WARM);
        check("rewarm_no_accept", saw, 0);
        in_valid = 1'b0;

        // Random traffic against the keystream scoreboard.
        n_in  = 0;
        n_out = 0;
        cyc   = 0;
        while (n_out < N_RAND && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            in_valid  = ($urandom_range(0, 3) != 0) && (n_in < N_RAND);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_unexpected_out", out_valid, 0);
                else check($sformatf("rand_word[%0d]", n_out), out_data, q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data ^ src_word(n_in));
                n_in++;
            end
        end
        check("rand_words_out", n_out, N_RAND);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Loopback: encrypt then decrypt with identical keystreams.
        @(negedge clk);
        lb_rst = 1'b0;
        pt   = 0;
        ecnt = 0;
        dcnt = 0;
        cyc  = 0;
        while (dcnt < N_LB && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            enc_in_valid = (pt < N_LB);
            enc_in_data  = 8'(pt);
            #1;
            if (enc_out_valid && enc_out_ready && ecnt < 10) begin
                check($sformatf("enc_word[%0d]", ecnt), enc_out_data, 8'(ecnt) ^ tri_word(ecnt));
                ecnt++;
            end
            if (dec_out_valid) begin
                check($sformatf("dec_word[%0d]", dcnt), dec_out_data, 8'(dcnt));
                dcnt++;
            end
            if (enc_in_valid && enc_in_ready) pt++;
        end
        enc_in_valid = 1'b0;
        check("lb_words", dcnt, N_LB);
        check("lb_enc_checked", ecnt, 10);
        check("lb_enc_warm", enc_warm_done, 1);
        check("lb_dec_warm", dec_warm_done, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
